inst_seq_player: RTL and testbench

Programmable instruction sequencer that sits directly upstream of the core top's instruction input. It stores a short list of RV32 instruction words, each with a hold count. On command it replays them onto the core's `inst` port cycle-accurately, so directed stimulus (jump, ALU and branch sequences) comes from a loadable table rather than hand-timed delays. Between runs it drives a canonical NOP so the core never sees X or a stale word.

---
 rtl/inst_seq_player.sv | 137 +++++++++++++
 tb/tb_inst_seq_player.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_seq_player.sv
// inst_seq_player: loadable instruction sequencer feeding a core's inst port.
// Holds up to DEPTH instruction words with per-entry hold counts and replays
// them back-to-back on start; drives NOP_INST whenever no entry is playing.
// Optional build macro INST_SEQ_LOOP_EN: playback wraps to entry 0 instead of
// returning to IDLE (done still pulses once per pass).
//
// state | meaning
// IDLE  | NOP on inst, waiting for start
// PLAY  | table entry cur_idx on inst, hold_cnt cycles left after this one
module inst_seq_player #(
  parameter int          DEPTH    = 8,
  parameter int          HOLD_W   = 8,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [31:0]                wr_inst,
  input  logic [HOLD_W-1:0]          wr_hold,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  input  logic                       stall,
  output logic [31:0]                inst,
  output logic                       inst_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   cur_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_inst [DEPTH];
  logic [HOLD_W-1:0] mem_hold [DEPTH];
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LW-1:0]     len_q, len_d;
  logic [AW-1:0]     idx_d, idx_nxt;
  logic [31:0]       inst_d;
  logic              valid_d, done_d;
  logic              last_entry;

  // A hold of 0 behaves like 1: the word is shown for one cycle.
  function automatic logic [HOLD_W-1:0] hold_init(input logic [HOLD_W-1:0] h);
    return (h == '0) ? '0 : h - 1'b1;
  endfunction

  assign idx_nxt    = cur_idx + 1'b1;
  assign last_entry = ({1'b0, cur_idx} == (len_q - 1'b1));
  assign busy       = (state_q == PLAY);

  // Table storage: plain synchronous write, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_inst[wr_addr] <= wr_inst;
      mem_hold[wr_addr] <= wr_hold;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      len_q      <= LW'(1);
      cur_idx    <= '0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      len_q      <= len_d;
      cur_idx    <= idx_d;
      inst       <= inst_d;
      inst_valid <= valid_d;
      done       <= done_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    len_d   = len_q;
    idx_d   = cur_idx;
    inst_d  = inst;
    valid_d = inst_valid;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0)
            len_d = LW'(1);
          else if (len > LW'(DEPTH))
            len_d = LW'(DEPTH);
          else
            len_d = len;
          idx_d   = '0;
          inst_d  = mem_inst[0];
          hold_d  = hold_init(mem_hold[0]);
          valid_d = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (!stall) begin
          if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end else if (!last_entry) begin
            idx_d  = idx_nxt;
            inst_d = mem_inst[idx_nxt];
            hold_d = hold_init(mem_hold[idx_nxt]);
          end else begin
            done_d = 1'b1;
`ifdef INST_SEQ_LOOP_EN
            idx_d  = '0;
            inst_d = mem_inst[0];
            hold_d = hold_init(mem_hold[0]);
`else
            idx_d   = '0;
            inst_d  = NOP_INST;
            hold_d  = '0;
            valid_d = 1'b0;
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_seq_player.sv
// Testbench for inst_seq_player: reference model expands each run into the
// per-cycle word list; a negedge monitor pops and compares it.
module tb_inst_seq_player;

  localparam int          DEPTH  = 8;
  localparam int          HOLD_W = 8;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_addr = '0;
  logic [31:0]       wr_inst = '0;
  logic [HOLD_W-1:0] wr_hold = '0;
  logic [3:0]        len = '0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic [31:0]       inst;
  logic              inst_valid, busy, done;
  logic [2:0]        cur_idx;

  inst_seq_player #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_inst(wr_inst), .wr_hold(wr_hold), .len(len), .start(start),
    .stall(stall), .inst(inst), .inst_valid(inst_valid), .busy(busy),
    .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  idx;
    logic        valid;
    logic        dn;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_inst [DEPTH];
  int          m_hold [DEPTH];
  int          checks = 0;
  int          passes = 0;
  bit          rstall = 0;
  bit          prev_frozen = 0;
  logic [31:0] prev_inst = '0;

  function void check(bit ok, string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endfunction

  // Monitor: every non-stalled presented word, and every done pulse, consumes one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      prev_frozen = 0;
    end else begin
      if (prev_frozen) check(inst === prev_inst, "stall_freeze", inst, prev_inst);
      if (inst_valid ? !stall : done) begin
        if (q.size() == 0) begin
          check(0, "unexpected_output", inst, NOP);
        end else begin
          exp_t e;
          bit   ok;
          e = q.pop_front();
          ok = (inst === e.w) && (inst_valid === e.valid) && (done === e.dn) &&
               (busy === e.valid) && (!e.valid || cur_idx === e.idx);
          checks++;
          if (ok) passes++;
          else $display("FAIL playback: got inst=%h idx=%0d valid=%b busy=%b done=%b, required inst=%h idx=%0d valid=%b busy=%b done=%b",
                        inst, cur_idx, inst_valid, busy, done, e.w, e.idx, e.valid, e.valid, e.dn);
        end
      end else if (!busy) begin
        check((inst === NOP) && (inst_valid === 1'b0), "idle_nop", inst, NOP);
      end
      prev_frozen = stall && busy && inst_valid;
      prev_inst   = inst;
    end
  end

  task automatic write_entry(input int a, input logic [31:0] w, input int h);
    wr_en = 1; wr_addr = 3'(a); wr_inst = w; wr_hold = HOLD_W'(h);
    @(posedge clk); #1;
    wr_en = 0;
    m_inst[a] = w; m_hold[a] = h;
  endtask

  // Model: clamp len, then each entry k shows max(hold,1) cycles, then one done/NOP cycle.
  task automatic push_run(input int l);
    int n;
    n = (l == 0) ? 1 : ((l > DEPTH) ? DEPTH : l);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < ((m_hold[k] == 0) ? 1 : m_hold[k]); c++)
        q.push_back('{m_inst[k], 3'(k), 1'b1, 1'b0});
    q.push_back('{NOP, 3'd0, 1'b0, 1'b1});
  endtask

  task automatic start_run(input int l);
    len = 4'(l); start = 1;
    push_run(l);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      stall = rstall ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    stall = 0;
    if (q.size() != 0) begin
      check(0, "drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(posedge clk); #1; n++; end
    if (!done) check(0, "done_timeout", 0, 1);
  endtask

  // Start, optionally stall 3 cycles at the start of entry 1, and check edges until done.
  task automatic timed_run(input int l, input bit do_stall, input int exp_cycles);
    int cnt = 0;
    int left = do_stall ? 3 : 0;
    start_run(l);
    while (!done && cnt < 200) begin
      if (left > 0 && cur_idx == 3'd1) begin stall = 1; left--; end
      else stall = 0;
      @(posedge clk); #1;
      cnt++;
    end
    stall = 0;
    check(cnt == exp_cycles, "done_latency", cnt, exp_cycles);
    drain(50);
  endtask

  task automatic load_plan_table();
    write_entry(0, 32'h0340006F, 2);
    write_entry(1, 32'h00200113, 2);
    write_entry(2, 32'h00200193, 9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1;
    check(cur_idx === 3'd0, "reset_cur_idx", cur_idx, 0);
    for (int i = 0; i < 5; i++) begin
      check((inst === NOP) && !inst_valid && !busy && !done, "reset_idle", inst, NOP);
      @(posedge clk); #1;
    end

`ifdef INST_SEQ_LOOP_EN
    write_entry(0, 32'h11111111, 1);
    write_entry(1, 32'h22222222, 1);
    len = 4'd2; start = 1;
    for (int w = 0; w < 4; w++) begin
      q.push_back('{32'h11111111, 3'd0, 1'b1, (w > 0)});
      q.push_back('{32'h22222222, 3'd1, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    start = 0;
    drain(40);
    reset = 0;
    #1 check((inst === NOP) && !busy && !inst_valid, "loop_reset", inst, NOP);
    @(posedge clk); #1 reset = 1;
`else
    load_plan_table();
    timed_run(3, 0, 13);
    timed_run(3, 1, 16);

    write_entry(3, 32'h00500293, 0);
    write_entry(0, 32'h00100093, 0);
    timed_run(1, 0, 1);
    timed_run(0, 0, 1);

    // Overwriting the entry on inst must not disturb it.
    write_entry(0, 32'hAAAA0001, 4);
    write_entry(1, 32'hAAAA0002, 1);
    start_run(2);
    write_entry(0, 32'hBBBB0001, 2);
    drain(50);
    start_run(1);
    drain(50);

    // Back-to-back: start in the done cycle.
    load_plan_table();
    start_run(3);
    wait_done(100);
    start_run(3);
    drain(100);

    // Asynchronous reset in the middle of entry 1, then replay.
    start_run(3);
    begin
      int n = 0;
      while (cur_idx != 3'd1 && n < 50) begin @(posedge clk); #1; n++; end
    end
    #2 reset = 0;
    #1;
    check(inst === NOP, "async_reset_inst", inst, NOP);
    check({inst_valid, busy, done} === 3'b000, "async_reset_flags", {inst_valid, busy, done}, 0);
    check(cur_idx === 3'd0, "async_reset_idx", cur_idx, 0);
    q.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    start_run(3);
    drain(100);

    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < DEPTH; a++) write_entry(a, $urandom, $urandom_range(0, 3));
      rstall = (r % 2 == 1);
      start_run($urandom_range(0, 12));
      if (r % 3 == 2) begin
        wait_done(300);
        start_run($urandom_range(1, 8));
      end
      drain(400);
      rstall = 0;
      @(posedge clk); #1;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
